// File: rtl/dm_arbiter_pkg.sv
// Shared state encodings, default arbitration limits and counter type for the DM arbiter.
package dm_arbiter_pkg;

  typedef enum logic [0:0] {
    CPU_PRI = 1'b0,
    ACC_PRI = 1'b1
  } arb_state_e;

  localparam int unsigned CNT_W          = 8;
  localparam int unsigned STARVE_MAX_DEF = 8;
  localparam int unsigned ACC_BURST_DEF  = 4;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/dm_arbiter_sat_cnt.sv
// 8-bit synchronous clear/increment counter that holds at LIMIT; clear wins over increment.
module sat_cnt
  import dm_arbiter_pkg::*;
#(
  parameter cnt_t LIMIT = 8'd255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: CPU DM stage wins by default, accelerator gets a bounded burst
// after STARVE_MAX blocked cycles. Zero-cycle grant; CPU is stalled only inside an ACC_PRI burst.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned ACC_BURST  = ACC_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam cnt_t STARVE_M1 = cnt_t'(STARVE_MAX - 1);
  localparam cnt_t BURST_M1  = cnt_t'(ACC_BURST - 1);

  arb_state_e state_q, state_d;
  logic       acc_rvalid_q, acc_rvalid_d;
  logic       cpu_acc, use_acc;
  logic       starve_clr, starve_inc, burst_clr, burst_inc;
  cnt_t       starve_cnt, burst_cnt;

  assign cpu_acc = cpu_re | cpu_we;

  // Memory-port mux; everything is forced quiet while reset is held.
  always_comb begin
    use_acc   = 1'b0;
    acc_gnt   = 1'b0;
    cpu_stall = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (rst_n) begin
      if ((state_q == ACC_PRI) && acc_req) begin
        use_acc   = 1'b1;
        cpu_stall = cpu_acc;
      end else if (cpu_acc) begin
        mem_re = cpu_re & ~cpu_we;
        mem_we = cpu_we;
      end else if (acc_req) begin
        use_acc = 1'b1;
      end
      if (use_acc) begin
        acc_gnt   = 1'b1;
        mem_re    = ~acc_we;
        mem_we    = acc_we;
        mem_addr  = acc_addr;
        mem_wdata = acc_wdata;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_inc   = (state_q == CPU_PRI) & acc_req & ~acc_gnt;
    starve_clr   = acc_gnt | ~acc_req | (state_q == ACC_PRI);
    burst_clr    = (state_q == CPU_PRI);
    burst_inc    = (state_q == ACC_PRI) & acc_gnt;
    acc_rvalid_d = acc_gnt & ~acc_we;
    case (state_q)
      CPU_PRI: if (starve_inc && (starve_cnt == STARVE_M1)) state_d = ACC_PRI;
      ACC_PRI: if (!acc_req || (acc_gnt && (burst_cnt == BURST_M1))) state_d = CPU_PRI;
      default: state_d = CPU_PRI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= CPU_PRI;
      acc_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_rvalid_q <= acc_rvalid_d;
    end
  end

  sat_cnt #(.LIMIT(cnt_t'(STARVE_MAX))) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (starve_clr),
    .inc   (starve_inc),
    .cnt   (starve_cnt)
  );

  sat_cnt #(.LIMIT(cnt_t'(ACC_BURST))) u_burst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (burst_clr),
    .inc   (burst_inc),
    .cnt   (burst_cnt)
  );

  assign acc_rvalid = acc_rvalid_q;
  assign acc_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed and constrained-random bench for dm_arbiter with a behavioural 1-cycle memory macro.
module tb_dm_arbiter;

  localparam int STARVE_MAX = 8;
  localparam int ACC_BURST  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_re, cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        acc_req, acc_we;
  logic [15:0] acc_addr;
  logic [31:0] acc_wdata, acc_rdata;
  logic        acc_gnt, acc_rvalid;
  logic        mem_re, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:65535];
  logic [31:0] ref_mem [0:15];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  dm_arbiter #(
    .ADDR_W(16), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .ACC_BURST(ACC_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  logic        exp_g, prev_g;
  logic        cpu_srv, acc_g_s;
  logic        acc_rd_pend, cpu_rd_pend;
  logic [31:0] acc_rd_exp, cpu_rd_exp;
  int          acc_wait, n_issued, n_done;
  int unsigned r;

  initial begin
    rst_n = 1'b0; cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = '0;
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 16'h0100; acc_wdata = '0;
    for (int k = 0; k < 16; k++) begin
      mem[16'h0020 + 16'(k)] <= 32'(k) * 32'h0101_0101;
      ref_mem[k] = 32'(k) * 32'h0101_0101;
    end
    mem[16'h0010] <= 32'h1234_5678;

    // Outputs stay quiet while reset is held, even with both masters requesting.
    next_cyc(); next_cyc();
    @(negedge clk);
    chk("rst_mem_re",     64'(mem_re), 64'd0);
    chk("rst_mem_we",     64'(mem_we), 64'd0);
    chk("rst_acc_gnt",    64'(acc_gnt), 64'd0);
    chk("rst_cpu_stall",  64'(cpu_stall), 64'd0);
    chk("rst_acc_rvalid", 64'(acc_rvalid), 64'd0);

    next_cyc(); rst_n = 1'b1; cpu_re = 1'b0; acc_req = 1'b0;
    @(negedge clk);
    chk("idle_mem_re",  64'(mem_re), 64'd0);
    chk("idle_acc_gnt", 64'(acc_gnt), 64'd0);

    next_cyc(); cpu_re = 1'b1; cpu_addr = 16'h0010;
    @(negedge clk);
    chk("ld_mem_re",   64'(mem_re), 64'd1);
    chk("ld_mem_we",   64'(mem_we), 64'd0);
    chk("ld_mem_addr", 64'(mem_addr), 64'h0010);
    chk("ld_stall",    64'(cpu_stall), 64'd0);
    next_cyc(); cpu_re = 1'b0;
    @(negedge clk);
    chk("ld_rdata", 64'(cpu_rdata), 64'h1234_5678);

    next_cyc(); acc_req = 1'b1; acc_we = 1'b1; acc_addr = 16'h0100; acc_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("aw_gnt",      64'(acc_gnt), 64'd1);
    chk("aw_mem_we",   64'(mem_we), 64'd1);
    chk("aw_mem_addr", 64'(mem_addr), 64'h0100);
    chk("aw_wdata",    64'(mem_wdata), 64'hDEAD_BEEF);
    next_cyc(); acc_we = 1'b0;
    @(negedge clk);
    chk("ar_gnt",    64'(acc_gnt), 64'd1);
    chk("ar_mem_re", 64'(mem_re), 64'd1);
    chk("ar_rvalid", 64'(acc_rvalid), 64'd0);
    next_cyc(); acc_req = 1'b0;
    @(negedge clk);
    chk("ar_rvalid2", 64'(acc_rvalid), 64'd1);
    chk("ar_rdata",   64'(acc_rdata), 64'hDEAD_BEEF);

    // Continuous CPU loads vs a held accelerator read: grants on cycles 8-11, then again from 20.
    next_cyc(); cpu_re = 1'b1; cpu_addr = 16'h0010; acc_req = 1'b1; acc_we = 1'b0; acc_addr = 16'h0100;
    prev_g = 1'b0;
    for (int c = 0; c < 22; c++) begin
      exp_g = ((c >= 8) && (c <= 11)) || (c >= 20);
      @(negedge clk);
      chk($sformatf("st_gnt_%0d", c),    64'(acc_gnt), 64'(exp_g));
      chk($sformatf("st_stall_%0d", c),  64'(cpu_stall), 64'(exp_g));
      chk($sformatf("st_addr_%0d", c),   64'(mem_addr), exp_g ? 64'h0100 : 64'h0010);
      chk($sformatf("st_rvalid_%0d", c), 64'(acc_rvalid), 64'(prev_g));
      prev_g = exp_g;
      next_cyc();
    end

    // Two grants into the window, the request drops: no stall and immediate exit.
    acc_req = 1'b0;
    @(negedge clk);
    chk("drop_stall",    64'(cpu_stall), 64'd0);
    chk("drop_gnt",      64'(acc_gnt), 64'd0);
    chk("drop_mem_re",   64'(mem_re), 64'd1);
    chk("drop_mem_addr", 64'(mem_addr), 64'h0010);

    next_cyc(); acc_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("re_gnt_%0d", c), 64'(acc_gnt), 64'd0);
      next_cyc();
    end
    @(negedge clk);
    chk("g1_gnt",   64'(acc_gnt), 64'd1);
    chk("g1_stall", 64'(cpu_stall), 64'd1);

    // Reset lands on the second burst grant.
    next_cyc(); rst_n = 1'b0;
    @(negedge clk);
    chk("rg_gnt",    64'(acc_gnt), 64'd0);
    chk("rg_stall",  64'(cpu_stall), 64'd0);
    chk("rg_mem_re", 64'(mem_re), 64'd0);
    next_cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("pr_rvalid",   64'(acc_rvalid), 64'd0);
    chk("pr_stall",    64'(cpu_stall), 64'd0);
    chk("pr_gnt",      64'(acc_gnt), 64'd0);
    chk("pr_mem_re",   64'(mem_re), 64'd1);
    chk("pr_mem_addr", 64'(mem_addr), 64'h0010);

    // Halted CPU: accelerator granted every cycle without ever opening a priority window.
    next_cyc(); cpu_re = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("h_gnt_%0d", c), 64'(acc_gnt), 64'd1);
      next_cyc();
    end
    cpu_re = 1'b1;
    @(negedge clk);
    chk("h_cpu_gnt",   64'(acc_gnt), 64'd0);
    chk("h_cpu_stall", 64'(cpu_stall), 64'd0);
    chk("h_cpu_addr",  64'(mem_addr), 64'h0010);

    // Random traffic over 16 shared words with a reference memory.
    next_cyc(); cpu_re = 1'b0; cpu_we = 1'b0; acc_req = 1'b0;
    acc_rd_pend = 1'b0; cpu_rd_pend = 1'b0; acc_rd_exp = '0; cpu_rd_exp = '0;
    acc_wait = 0; n_issued = 0; n_done = 0;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      chk("rnd_excl", 64'(mem_re & mem_we), 64'd0);
      cpu_srv = (cpu_re | cpu_we) & ~cpu_stall;
      acc_g_s = acc_gnt;
      chk("rnd_one_master", 64'(cpu_srv & acc_gnt), 64'd0);
      chk("rnd_gnt_req", 64'(acc_gnt & ~acc_req), 64'd0);
      chk("rnd_rvalid", 64'(acc_rvalid), 64'(acc_rd_pend));
      if (acc_rd_pend) chk("rnd_acc_rdata", 64'(acc_rdata), 64'(acc_rd_exp));
      if (cpu_rd_pend) chk("rnd_cpu_rdata", 64'(cpu_rdata), 64'(cpu_rd_exp));
      acc_rd_pend = 1'b0;
      cpu_rd_pend = 1'b0;
      if (acc_req) begin
        acc_wait++;
        chk("rnd_acc_wait", 64'(acc_wait <= STARVE_MAX + 1), 64'd1);
        if (acc_gnt) begin
          n_done++;
          chk("rnd_acc_addr", 64'(mem_addr), 64'(acc_addr));
          chk("rnd_acc_we",   64'(mem_we), 64'(acc_we));
          if (acc_we) ref_mem[acc_addr[3:0]] = acc_wdata;
          else begin acc_rd_pend = 1'b1; acc_rd_exp = ref_mem[acc_addr[3:0]]; end
        end
      end
      if (cpu_srv) begin
        chk("rnd_cpu_addr", 64'(mem_addr), 64'(cpu_addr));
        if (cpu_we) ref_mem[cpu_addr[3:0]] = cpu_wdata;
        else begin cpu_rd_pend = 1'b1; cpu_rd_exp = ref_mem[cpu_addr[3:0]]; end
      end
      next_cyc();
      if (!(cpu_re | cpu_we) || cpu_srv) begin
        r = (i < 400) ? $urandom_range(0, 7) : 0;
        cpu_re    = (r == 1) || (r == 2) || (r == 3) || (r == 6);
        cpu_we    = (r == 4) || (r == 5) || (r == 6);
        cpu_addr  = 16'h0020 + 16'($urandom_range(0, 15));
        cpu_wdata = $urandom();
      end
      if (!acc_req || acc_g_s) begin
        acc_wait = 0;
        if ((i < 400) && ($urandom_range(0, 3) != 0)) begin
          acc_req   = 1'b1;
          acc_we    = 1'($urandom_range(0, 1));
          acc_addr  = 16'h0020 + 16'($urandom_range(0, 15));
          acc_wdata = $urandom();
          n_issued++;
        end else begin
          acc_req = 1'b0;
        end
      end
    end
    chk("rnd_acc_count", 64'(n_done), 64'(n_issued));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
